// File: rtl/csr_access_arbiter.sv
// Arbitrates core and debug requesters onto the shared combinational CSR unit,
// one transaction in flight, with registered commit, writeback and response.
module csr_access_arbiter #(
   parameter int CSR_REQ_WIDTH_P  = 71,
   parameter int CSR_RESP_WIDTH_P = 99,
   parameter int CSR_WB_WIDTH_P   = 53,
   parameter int ILL_CNT_WIDTH    = 16
) (
   input  logic                        clk,
   input  logic                        rst_n,
   input  logic                        core_valid,
   output logic                        core_ready,
   input  logic [CSR_REQ_WIDTH_P-1:0]  core_req,
   input  logic                        core_flush,
   input  logic                        dbg_valid,
   output logic                        dbg_ready,
   input  logic [CSR_REQ_WIDTH_P-1:0]  dbg_req,
   output logic [CSR_REQ_WIDTH_P-1:0]  unit_req,
   input  logic [CSR_RESP_WIDTH_P-1:0] unit_resp,
   input  logic [CSR_WB_WIDTH_P-1:0]   unit_wb,
   output logic                        csr_wr_en,
   output logic [11:0]                 csr_wr_addr,
   output logic [47:0]                 csr_wr_data,
   output logic [CSR_WB_WIDTH_P-1:0]   wb_out,
   output logic                        rsp_valid,
   input  logic                        rsp_ready,
   output logic                        rsp_owner,
   output logic                        rsp_ok,
   output logic                        rsp_illegal,
   output logic [47:0]                 rsp_rdata,
   output logic                        busy,
   output logic [ILL_CNT_WIDTH-1:0]    ill_count
);

   // Field positions of the packed request/response, as laid out in cpu_ad48_csr_if.vh
   localparam int REQ_VALID_BIT  = 70;
   localparam int REQ_PRIV_LSB   = 64;
   localparam int REQ_ADDR_LSB   = 52;
   localparam int RESP_OK_BIT    = 98;
   localparam int RESP_ILL_BIT   = 97;
   localparam int RESP_WE_BIT    = 96;
   localparam int RESP_WDATA_LSB = 48;
   localparam int RESP_RDATA_LSB = 0;

   typedef enum logic [1:0] {IDLE, ISSUE, RESP} state_t;

   state_t                       state_q, state_d;
   logic                         rr_last_q, rr_last_d;
   logic                         owner_q, owner_d;
   logic [CSR_REQ_WIDTH_P-1:0]   unit_req_q, unit_req_d;
   logic                         csr_wr_en_q, csr_wr_en_d;
   logic [11:0]                  csr_wr_addr_q, csr_wr_addr_d;
   logic [47:0]                  csr_wr_data_q, csr_wr_data_d;
   logic [CSR_WB_WIDTH_P-1:0]    wb_out_q, wb_out_d;
   logic                         rsp_valid_q, rsp_valid_d;
   logic                         rsp_owner_q, rsp_owner_d;
   logic                         rsp_ok_q, rsp_ok_d;
   logic                         rsp_illegal_q, rsp_illegal_d;
   logic [47:0]                  rsp_rdata_q, rsp_rdata_d;
   logic [ILL_CNT_WIDTH-1:0]     ill_count_q, ill_count_d;
   logic                         core_squash;

   assign core_squash = !owner_q && core_flush;

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q <= IDLE;
      end else begin
         state_q <= state_d;
      end
   end

   always_comb begin
      state_d = state_q;
      case (state_q)
         IDLE:    if (core_ready || dbg_ready) state_d = ISSUE;
         ISSUE:   state_d = core_squash ? IDLE : RESP;
         RESP:    if (rsp_ready || core_squash) state_d = IDLE;
         default: state_d = IDLE;
      endcase
   end

   // rr_last==1 means debug was granted last, so core wins the next tie
   always_comb begin
      core_ready = (state_q == IDLE) && core_valid && !core_flush && (!dbg_valid || rr_last_q);
      dbg_ready  = (state_q == IDLE) && dbg_valid && !core_ready;
      busy       = (state_q != IDLE);
   end

   always_comb begin
      rr_last_d     = rr_last_q;
      owner_d       = owner_q;
      unit_req_d    = unit_req_q;
      csr_wr_en_d   = 1'b0;
      csr_wr_addr_d = csr_wr_addr_q;
      csr_wr_data_d = csr_wr_data_q;
      wb_out_d      = '0;
      rsp_valid_d   = rsp_valid_q;
      rsp_owner_d   = rsp_owner_q;
      rsp_ok_d      = rsp_ok_q;
      rsp_illegal_d = rsp_illegal_q;
      rsp_rdata_d   = rsp_rdata_q;
      ill_count_d   = ill_count_q;
      case (state_q)
         IDLE: begin
            if (core_ready) begin
               unit_req_d                = core_req;
               unit_req_d[REQ_VALID_BIT] = 1'b1;
               owner_d                   = 1'b0;
               rr_last_d                 = 1'b0;
            end else if (dbg_ready) begin
               unit_req_d                                   = dbg_req;
               unit_req_d[REQ_VALID_BIT]                    = 1'b1;
               unit_req_d[REQ_PRIV_LSB+1:REQ_PRIV_LSB]      = 2'd3;
               owner_d                                      = 1'b1;
               rr_last_d                                    = 1'b1;
            end
         end
         ISSUE: begin
            if (core_squash) begin
               unit_req_d = '0;
            end else begin
               csr_wr_en_d               = unit_resp[RESP_WE_BIT];
               csr_wr_addr_d             = unit_req_q[REQ_ADDR_LSB+11:REQ_ADDR_LSB];
               csr_wr_data_d             = unit_resp[RESP_WDATA_LSB+47:RESP_WDATA_LSB];
               wb_out_d                  = owner_q ? '0 : unit_wb;
               rsp_valid_d               = 1'b1;
               rsp_owner_d               = owner_q;
               rsp_ok_d                  = unit_resp[RESP_OK_BIT];
               rsp_illegal_d             = unit_resp[RESP_ILL_BIT];
               rsp_rdata_d               = unit_resp[RESP_RDATA_LSB+47:RESP_RDATA_LSB];
               unit_req_d[REQ_VALID_BIT] = 1'b0;
               if (unit_resp[RESP_ILL_BIT] && (ill_count_q != '1)) begin
                  ill_count_d = ill_count_q + ILL_CNT_WIDTH'(1);
               end
            end
         end
         RESP: begin
            if (rsp_ready || core_squash) rsp_valid_d = 1'b0;
         end
         default: ;
      endcase
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         rr_last_q     <= 1'b1;
         owner_q       <= 1'b0;
         unit_req_q    <= '0;
         csr_wr_en_q   <= 1'b0;
         csr_wr_addr_q <= '0;
         csr_wr_data_q <= '0;
         wb_out_q      <= '0;
         rsp_valid_q   <= 1'b0;
         rsp_owner_q   <= 1'b0;
         rsp_ok_q      <= 1'b0;
         rsp_illegal_q <= 1'b0;
         rsp_rdata_q   <= '0;
         ill_count_q   <= '0;
      end else begin
         rr_last_q     <= rr_last_d;
         owner_q       <= owner_d;
         unit_req_q    <= unit_req_d;
         csr_wr_en_q   <= csr_wr_en_d;
         csr_wr_addr_q <= csr_wr_addr_d;
         csr_wr_data_q <= csr_wr_data_d;
         wb_out_q      <= wb_out_d;
         rsp_valid_q   <= rsp_valid_d;
         rsp_owner_q   <= rsp_owner_d;
         rsp_ok_q      <= rsp_ok_d;
         rsp_illegal_q <= rsp_illegal_d;
         rsp_rdata_q   <= rsp_rdata_d;
         ill_count_q   <= ill_count_d;
      end
   end

   assign unit_req    = unit_req_q;
   assign csr_wr_en   = csr_wr_en_q;
   assign csr_wr_addr = csr_wr_addr_q;
   assign csr_wr_data = csr_wr_data_q;
   assign wb_out      = wb_out_q;
   assign rsp_valid   = rsp_valid_q;
   assign rsp_owner   = rsp_owner_q;
   assign rsp_ok      = rsp_ok_q;
   assign rsp_illegal = rsp_illegal_q;
   assign rsp_rdata   = rsp_rdata_q;
   assign ill_count   = ill_count_q;

endmodule

// File: tb/tb_csr_access_arbiter.sv
// Directed bench for csr_access_arbiter: a small CSR unit model plus a vector
// table and hand-written sequences for flush, backpressure and reset.
module tb_csr_access_arbiter;

   logic         clk;
   logic         rst_n;
   logic         core_valid, core_ready, core_flush;
   logic [70:0]  core_req;
   logic         dbg_valid, dbg_ready;
   logic [70:0]  dbg_req;
   logic [70:0]  unit_req;
   logic [98:0]  unit_resp;
   logic [52:0]  unit_wb;
   logic         csr_wr_en;
   logic [11:0]  csr_wr_addr;
   logic [47:0]  csr_wr_data;
   logic [52:0]  wb_out;
   logic         rsp_valid, rsp_ready, rsp_owner, rsp_ok, rsp_illegal;
   logic [47:0]  rsp_rdata;
   logic         busy;
   logic [2:0]   ill_count;

   int total = 0;
   int bad   = 0;
   logic [2:0] exp_ill_cnt = 3'd0;

   csr_access_arbiter #(
      .CSR_REQ_WIDTH_P (71),
      .CSR_RESP_WIDTH_P(99),
      .CSR_WB_WIDTH_P  (53),
      .ILL_CNT_WIDTH   (3)
   ) dut (
      .clk(clk), .rst_n(rst_n),
      .core_valid(core_valid), .core_ready(core_ready), .core_req(core_req), .core_flush(core_flush),
      .dbg_valid(dbg_valid), .dbg_ready(dbg_ready), .dbg_req(dbg_req),
      .unit_req(unit_req), .unit_resp(unit_resp), .unit_wb(unit_wb),
      .csr_wr_en(csr_wr_en), .csr_wr_addr(csr_wr_addr), .csr_wr_data(csr_wr_data),
      .wb_out(wb_out),
      .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_owner(rsp_owner),
      .rsp_ok(rsp_ok), .rsp_illegal(rsp_illegal), .rsp_rdata(rsp_rdata),
      .busy(busy), .ill_count(ill_count)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   // CSR unit model: funcs 1=RW 2=RS 3=RC 4=RD; priv 0 or unknown func is illegal
   logic [3:0]  m_func, m_rd;
   logic [1:0]  m_priv;
   logic [11:0] m_addr;
   logic [47:0] m_src, m_csr, m_wdata;
   logic        m_known, m_ill, m_ok, m_we;
   always_comb begin
      m_func  = unit_req[69:66];
      m_priv  = unit_req[65:64];
      m_addr  = unit_req[63:52];
      m_rd    = unit_req[51:48];
      m_src   = unit_req[47:0];
      m_csr   = {36'hFEDCBA987, m_addr};
      m_known = (m_func >= 4'd1) && (m_func <= 4'd4);
      m_ill   = unit_req[70] && (!m_known || (m_priv == 2'd0));
      m_ok    = unit_req[70] && !m_ill;
      m_we    = m_ok && (m_func != 4'd4);
      case (m_func)
         4'd1:    m_wdata = m_src;
         4'd2:    m_wdata = m_csr | m_src;
         4'd3:    m_wdata = m_csr & ~m_src;
         default: m_wdata = 48'h0;
      endcase
      if (!m_we) m_wdata = 48'h0;
      unit_resp = {m_ok, m_ill, m_we, m_wdata, (m_ok ? m_csr : 48'h0)};
      unit_wb   = m_ok ? {1'b1, m_rd, m_csr} : 53'h0;
   end

   typedef struct {
      bit          is_dbg;
      logic [3:0]  func;
      logic [1:0]  priv;
      logic [11:0] addr;
      logic [3:0]  rd;
      logic [47:0] src;
      bit          exp_we;
      logic [47:0] exp_wdata;
      bit          exp_ok;
      bit          exp_ill;
      logic [47:0] exp_rdata;
      bit          exp_wb;
   } vec_t;

   vec_t vecs[6];
   vec_t ill_vec;

   function automatic logic [70:0] make_req(input logic [3:0] f, input logic [1:0] p,
                                            input logic [11:0] a, input logic [3:0] rd,
                                            input logic [47:0] s);
      return {1'b0, f, p, a, rd, s};
   endfunction

   task automatic check_output(input string name, input logic [63:0] act, input logic [63:0] exp);
      total++;
      if (act !== exp) begin
         bad++;
         $display("[TB] FAIL %s: got %0h expected %0h", name, act, exp);
      end
   endtask

   // Runs one transaction from IDLE with rsp_ready high; entered at posedge+1
   task automatic apply_stimulus(input vec_t v);
      rsp_ready = 1'b1;
      if (v.is_dbg) begin
         dbg_valid = 1'b1;
         dbg_req   = make_req(v.func, v.priv, v.addr, v.rd, v.src);
      end else begin
         core_valid = 1'b1;
         core_req   = make_req(v.func, v.priv, v.addr, v.rd, v.src);
      end
      @(negedge clk);
      check_output("grant", {62'h0, core_ready, dbg_ready}, v.is_dbg ? 64'h1 : 64'h2);
      @(posedge clk);
      #1;
      core_valid = 1'b0;
      dbg_valid  = 1'b0;
      @(negedge clk);
      check_output("issue_busy", {63'h0, busy}, 64'h1);
      check_output("issue_no_commit", {63'h0, csr_wr_en}, 64'h0);
      check_output("issue_rsp_valid", {63'h0, rsp_valid}, 64'h0);
      check_output("issue_req_valid", {63'h0, unit_req[70]}, 64'h1);
      check_output("issue_priv", {62'h0, unit_req[65:64]}, v.is_dbg ? 64'h3 : {62'h0, v.priv});
      if (v.exp_ill && (exp_ill_cnt != 3'd7)) exp_ill_cnt = exp_ill_cnt + 3'd1;
      @(negedge clk);
      check_output("resp_busy", {63'h0, busy}, 64'h1);
      check_output("resp_valid", {63'h0, rsp_valid}, 64'h1);
      check_output("wr_en", {63'h0, csr_wr_en}, {63'h0, v.exp_we});
      check_output("wr_addr", {52'h0, csr_wr_addr}, {52'h0, v.addr});
      check_output("wr_data", {16'h0, csr_wr_data}, {16'h0, v.exp_wdata});
      check_output("owner", {63'h0, rsp_owner}, {63'h0, v.is_dbg});
      check_output("ok", {63'h0, rsp_ok}, {63'h0, v.exp_ok});
      check_output("illegal", {63'h0, rsp_illegal}, {63'h0, v.exp_ill});
      check_output("rdata", {16'h0, rsp_rdata}, {16'h0, v.exp_rdata});
      check_output("wb_out", {11'h0, wb_out}, v.exp_wb ? {11'h0, 1'b1, v.rd, v.exp_rdata} : 64'h0);
      check_output("req_valid_clr", {63'h0, unit_req[70]}, 64'h0);
      check_output("ill_count", {61'h0, ill_count}, {61'h0, exp_ill_cnt});
      @(negedge clk);
      check_output("idle_wr_en", {63'h0, csr_wr_en}, 64'h0);
      check_output("idle_wb", {11'h0, wb_out}, 64'h0);
      check_output("idle_rsp_valid", {63'h0, rsp_valid}, 64'h0);
      check_output("idle_busy", {63'h0, busy}, 64'h0);
      @(posedge clk);
      #1;
   endtask

   initial begin
      #100000;
      $display("[TB] FAIL timeout: got running expected finished");
      $fatal(1, "[TB] timeout");
   end

   initial begin
      vecs[0] = '{1'b0, 4'd1, 2'd1, 12'h001, 4'd5, 48'h123456789ABC,
                  1'b1, 48'h123456789ABC, 1'b1, 1'b0, 48'hFEDCBA987001, 1'b1};
      vecs[1] = '{1'b0, 4'd4, 2'd0, 12'h010, 4'd6, 48'h0,
                  1'b0, 48'h0, 1'b0, 1'b1, 48'h0, 1'b0};
      vecs[2] = '{1'b1, 4'd2, 2'd0, 12'h300, 4'd7, 48'h0000000000F0,
                  1'b1, 48'hFEDCBA9873F0, 1'b1, 1'b0, 48'hFEDCBA987300, 1'b0};
      vecs[3] = '{1'b0, 4'd3, 2'd3, 12'h342, 4'd8, 48'hFFFF00000000,
                  1'b1, 48'h0000BA987342, 1'b1, 1'b0, 48'hFEDCBA987342, 1'b1};
      vecs[4] = '{1'b0, 4'hF, 2'd3, 12'h005, 4'd9, 48'h55,
                  1'b0, 48'h0, 1'b0, 1'b1, 48'h0, 1'b0};
      vecs[5] = '{1'b1, 4'd4, 2'd1, 12'h7C0, 4'd2, 48'h0,
                  1'b0, 48'h0, 1'b1, 1'b0, 48'hFEDCBA9877C0, 1'b0};
      ill_vec = vecs[1];

      rst_n = 1'b0; core_valid = 1'b0; core_flush = 1'b0; core_req = '0;
      dbg_valid = 1'b0; dbg_req = '0; rsp_ready = 1'b1;
      #3;
      check_output("rst_busy", {63'h0, busy}, 64'h0);
      check_output("rst_unit_req", unit_req[63:0] | {63'h0, unit_req[70]}, 64'h0);
      check_output("rst_rsp_valid", {63'h0, rsp_valid}, 64'h0);
      check_output("rst_ill", {61'h0, ill_count}, 64'h0);
      @(posedge clk);
      #1 rst_n = 1'b1;
      @(posedge clk);
      #1;

      for (int i = 0; i < 6; i++) apply_stimulus(vecs[i]);

      // Both requesters always valid: grants alternate starting with core
      core_req  = make_req(4'd1, 2'd1, 12'h0AA, 4'd1, 48'h1);
      dbg_req   = make_req(4'd4, 2'd0, 12'h0BB, 4'd2, 48'h0);
      core_valid = 1'b1;
      dbg_valid  = 1'b1;
      for (int i = 0; i < 6; i++) begin
         for (int k = 0; k < 8; k++) begin
            @(negedge clk);
            if (core_ready || dbg_ready) break;
         end
         check_output("alt_grant", {62'h0, core_ready, dbg_ready}, (i % 2 == 0) ? 64'h2 : 64'h1);
         @(negedge clk);
         check_output("alt_priv", {62'h0, unit_req[65:64]}, (i % 2 == 0) ? 64'h1 : 64'h3);
      end
      core_valid = 1'b0;
      dbg_valid  = 1'b0;
      @(posedge clk);
      @(posedge clk);
      #1;

      // Illegal counter saturates at all-ones (width 3 here)
      for (int i = 0; i < 6; i++) apply_stimulus(ill_vec);
      check_output("ill_sat", {61'h0, ill_count}, 64'h7);

      // Flush during ISSUE squashes the core write; pending debug is then accepted
      core_req   = make_req(4'd1, 2'd1, 12'h002, 4'd3, 48'hDEAD0000BEEF);
      core_valid = 1'b1;
      @(negedge clk);
      check_output("fl_core_ready", {63'h0, core_ready}, 64'h1);
      @(posedge clk);
      #1;
      core_valid = 1'b0;
      core_flush = 1'b1;
      dbg_valid  = 1'b1;
      dbg_req    = make_req(4'd4, 2'd0, 12'h300, 4'd1, 48'h0);
      @(negedge clk);
      check_output("fl_issue_dbg_ready", {63'h0, dbg_ready}, 64'h0);
      @(posedge clk);
      #1 core_flush = 1'b0;
      @(negedge clk);
      check_output("fl_no_commit", {63'h0, csr_wr_en}, 64'h0);
      check_output("fl_no_rsp", {63'h0, rsp_valid}, 64'h0);
      check_output("fl_idle", {63'h0, busy}, 64'h0);
      check_output("fl_req_clr", {63'h0, unit_req[70]}, 64'h0);
      check_output("fl_dbg_ready", {63'h0, dbg_ready}, 64'h1);
      @(posedge clk);
      #1 dbg_valid = 1'b0;
      @(negedge clk);
      @(negedge clk);
      check_output("fl_dbg_rsp", {63'h0, rsp_valid}, 64'h1);
      check_output("fl_dbg_owner", {63'h0, rsp_owner}, 64'h1);
      check_output("fl_dbg_rdata", {16'h0, rsp_rdata}, 64'hFEDCBA987300);
      @(posedge clk);
      #1;

      // Flush during RESP drops the response but the commit already happened
      rsp_ready  = 1'b0;
      core_req   = make_req(4'd1, 2'd1, 12'h003, 4'd4, 48'h111);
      core_valid = 1'b1;
      @(posedge clk);
      #1 core_valid = 1'b0;
      @(posedge clk);
      #1 core_flush = 1'b1;
      @(negedge clk);
      check_output("flr_commit", {63'h0, csr_wr_en}, 64'h1);
      check_output("flr_data", {16'h0, csr_wr_data}, 64'h111);
      check_output("flr_rsp_valid", {63'h0, rsp_valid}, 64'h1);
      @(posedge clk);
      #1 core_flush = 1'b0;
      @(negedge clk);
      check_output("flr_dropped", {63'h0, rsp_valid}, 64'h0);
      check_output("flr_idle", {63'h0, busy}, 64'h0);
      @(posedge clk);
      #1;

      // Response backpressure: outputs hold, commit is a single pulse, no grants
      dbg_req   = make_req(4'd2, 2'd2, 12'h340, 4'd1, 48'h1);
      dbg_valid = 1'b1;
      @(posedge clk);
      #1 dbg_valid = 1'b0;
      @(posedge clk);
      #1;
      core_valid = 1'b1;
      dbg_valid  = 1'b1;
      for (int i = 0; i < 5; i++) begin
         @(negedge clk);
         check_output("bp_rsp_valid", {63'h0, rsp_valid}, 64'h1);
         check_output("bp_rdata", {16'h0, rsp_rdata}, 64'hFEDCBA987340);
         check_output("bp_wr_en", {63'h0, csr_wr_en}, (i == 0) ? 64'h1 : 64'h0);
         check_output("bp_readies", {62'h0, core_ready, dbg_ready}, 64'h0);
      end
      check_output("bp_wr_data", {16'h0, csr_wr_data}, 64'hFEDCBA987341);
      rsp_ready  = 1'b1;
      core_valid = 1'b0;
      dbg_valid  = 1'b0;
      @(negedge clk);
      check_output("bp_release", {63'h0, rsp_valid}, 64'h0);
      @(posedge clk);
      #1;

      // Asynchronous reset in RESP clears outputs without waiting for a clock
      rsp_ready  = 1'b0;
      core_req   = make_req(4'd1, 2'd1, 12'h004, 4'd3, 48'hABC);
      core_valid = 1'b1;
      @(posedge clk);
      #1 core_valid = 1'b0;
      @(negedge clk);
      @(negedge clk);
      check_output("ar_in_resp", {63'h0, rsp_valid}, 64'h1);
      #2 rst_n = 1'b0;
      #1;
      check_output("ar_rsp_valid", {63'h0, rsp_valid}, 64'h0);
      check_output("ar_busy", {63'h0, busy}, 64'h0);
      check_output("ar_wr", {51'h0, csr_wr_en, csr_wr_addr}, 64'h0);
      check_output("ar_wr_data", {16'h0, csr_wr_data}, 64'h0);
      check_output("ar_rsp_fields", {45'h0, rsp_owner, rsp_ok, rsp_illegal, rsp_rdata[15:0]}, 64'h0);
      check_output("ar_ill_count", {61'h0, ill_count}, 64'h0);
      check_output("ar_unit_req", {63'h0, unit_req[70]}, 64'h0);
      @(posedge clk);
      #1;
      rst_n      = 1'b1;
      rsp_ready  = 1'b1;
      core_valid = 1'b1;
      dbg_valid  = 1'b1;
      @(negedge clk);
      check_output("ar_first_tie", {62'h0, core_ready, dbg_ready}, 64'h2);
      @(posedge clk);
      #1;
      core_valid = 1'b0;
      dbg_valid  = 1'b0;
      repeat (3) @(posedge clk);

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
